// File: rtl/osbm.sv
// Output-side switch buffer manager: round-robin grant of one input per packet,
// drives that input's read enable and forwards its flits until the tail passes.
module osbm #(
    parameter int NPORT  = 4,
    parameter int OUT_ID = 0,
    parameter int DW     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT*NPORT-1:0] req_in,
    input  logic [NPORT-1:0]       empty,
    input  logic [NPORT*DW-1:0]    din,
    input  logic [NPORT*2-1:0]     cmd_in,
    input  logic                   full,
    output logic [NPORT-1:0]       ack,
    output logic [DW-1:0]          dout,
    output logic [1:0]             cmd_out,
    output logic                   we
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [1:0] CMD_TAIL = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   grant_reg, grant_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [DW-1:0]   dout_reg, dout_next;
    logic [1:0]      cmd_reg, cmd_next;
    logic            we_reg, we_next;

    logic [NPORT-1:0] cand;
    logic [DW-1:0]    din_arr [NPORT];
    logic [1:0]       cmd_arr [NPORT];
    logic [DW-1:0]    sel_data;
    logic [1:0]       sel_cmd;
    logic             xfer;
    logic [PW-1:0]    pick;
    logic             pick_valid;
    int               idx;

    // Only bit OUT_ID of each slice matters; the reduction keeps the rest visibly consumed.
    logic unused_req_bits;
    assign unused_req_bits = ^req_in;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign cand[gi]    = req_in[gi*NPORT + OUT_ID];
            assign din_arr[gi] = din[gi*DW +: DW];
            assign cmd_arr[gi] = cmd_in[gi*2 +: 2];
        end
    endgenerate

    assign sel_data = din_arr[grant_reg];
    assign sel_cmd  = cmd_arr[grant_reg];

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        pick       = rr_ptr_reg;
        pick_valid = 1'b0;
        idx        = 0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (cand[PW'(idx)]) begin
                pick       = PW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ack = '0;
        if ((state_reg == GRANT) && !empty[grant_reg] && !full) begin
            ack[grant_reg] = 1'b1;
        end
    end

    assign xfer = |ack;

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        dout_next   = dout_reg;
        cmd_next    = cmd_reg;
        we_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next = pick;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    dout_next = sel_data;
                    cmd_next  = sel_cmd;
                    we_next   = 1'b1;
                    // Only a tail releases the grant; the finisher drops to lowest priority.
                    if (sel_cmd == CMD_TAIL) begin
                        state_next  = IDLE;
                        rr_ptr_next = (grant_reg == PW'(NPORT - 1)) ? '0 : grant_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            dout_reg   <= '0;
            cmd_reg    <= '0;
            we_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            dout_reg   <= dout_next;
            cmd_reg    <= cmd_next;
            we_reg     <= we_next;
        end
    end

    assign dout    = dout_reg;
    assign cmd_out = cmd_reg;
    assign we      = we_reg;

endmodule

// File: tb/tb_osbm.sv
// Randomized scoreboard bench for osbm: input FIFOs and req latches are emulated,
// a packet-level round-robin model predicts acks and the forwarded flit stream.
module tb_osbm;
    localparam int NP     = 4;
    localparam int DW     = 32;
    localparam int OUT_ID = 0;
    localparam int DEPTH  = 1024;
    localparam logic [1:0] C_BODY = 2'b01;
    localparam logic [1:0] C_HEAD = 2'b10;
    localparam logic [1:0] C_TAIL = 2'b11;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [DW-1:0] data;
    } flit_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*NP-1:0]  req_in;
    logic [NP-1:0]     empty;
    logic [NP*DW-1:0]  din;
    logic [NP*2-1:0]   cmd_in;
    logic              full;
    logic [NP-1:0]     ack;
    logic [DW-1:0]     dout;
    logic [1:0]        cmd_out;
    logic              we;

    osbm #(.NPORT(NP), .OUT_ID(OUT_ID), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .empty(empty), .din(din),
        .cmd_in(cmd_in), .full(full), .ack(ack), .dout(dout), .cmd_out(cmd_out), .we(we)
    );

    always #5 clk = ~clk;

    flit_t       mem [NP][DEPTH];
    int          wr [NP], rd [NP], m_rd [NP], st_empty [NP];
    int          st_full;
    logic [NP-1:0] req_reg, exp_ack;
    int          m_owner, m_ptr;
    flit_t       exp_q [$];
    int          exp_head_q [$];
    logic        chk_en  = 1'b0;
    logic        gap_chk = 1'b0;
    int          checks = 0, fails = 0;
    int          cyc = 0, last_tail = -1;
    flit_t       mon_e;
    int          mon_h;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every cycle and pops the scoreboard whenever a flit is presented.
    always @(negedge clk) begin
        if (!rst) begin
            last_tail = -1;
            checks++;
            if (ack !== '0 || we !== 1'b0 || dout !== '0 || cmd_out !== 2'b00) begin
                fails++;
                $display("FAIL reset_state: ack=%b we=%b dout=%h cmd_out=%b, required all zero", ack, we, dout, cmd_out);
            end
        end else if (chk_en) begin
            checks++;
            if (ack !== exp_ack) begin
                fails++;
                $display("FAIL ack @%0d: got %b, expected %b", cyc, ack, exp_ack);
            end
            checks++;
            if (!$onehot0(ack)) begin
                fails++;
                $display("FAIL ack_onehot @%0d: got %b", cyc, ack);
            end
            if (we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_flit @%0d: cmd=%b data=%h, expected none", cyc, cmd_out, dout);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({cmd_out, dout} !== mon_e) begin
                        fails++;
                        $display("FAIL flit @%0d: got cmd=%b data=%h, expected cmd=%b data=%h",
                                 cyc, cmd_out, dout, mon_e.cmd, mon_e.data);
                    end
                end
                if (cmd_out == C_HEAD && exp_head_q.size() > 0) begin
                    mon_h = exp_head_q.pop_front();
                    checks++;
                    if (int'(dout[31:24]) != mon_h) begin
                        fails++;
                        $display("FAIL service_order @%0d: got port %0d, expected port %0d", cyc, dout[31:24], mon_h);
                    end
                end
                if (cmd_out == C_HEAD && gap_chk && last_tail >= 0) begin
                    checks++;
                    if (cyc - last_tail != 2) begin
                        fails++;
                        $display("FAIL packet_gap @%0d: got %0d cycles tail-to-head, expected 2", cyc, cyc - last_tail);
                    end
                end
                if (cmd_out == C_TAIL) last_tail = cyc;
            end
        end
    end

    task automatic add_pkt(input int p, input int len, input bit mixed);
        flit_t f;
        for (int i = 0; i < len; i++) begin
            f.data = {8'(p), 24'($urandom)};
            if (i == 0)            f.cmd = C_HEAD;
            else if (i == len - 1) f.cmd = C_TAIL;
            else                   f.cmd = (mixed && $urandom_range(0, 5) == 0) ? C_HEAD : C_BODY;
            mem[p][wr[p] % DEPTH] = f;
            wr[p]++;
        end
    endtask

    task automatic drive();
        logic [NP*NP-1:0] r;
        logic [NP-1:0]    stl;
        r = 16'($urandom);
        for (int p = 0; p < NP; p++) begin
            stl[p] = (st_empty[p] > 0);
            if (st_empty[p] > 0) st_empty[p]--;
            r[p*NP + OUT_ID]   = req_reg[p];
            empty[p]           = (rd[p] == wr[p]) || stl[p];
            din[p*DW +: DW]    = mem[p][rd[p] % DEPTH].data;
            cmd_in[p*2 +: 2]   = mem[p][rd[p] % DEPTH].cmd;
        end
        req_in = r;
        full   = (st_full > 0);
        exp_ack = '0;
        if (m_owner >= 0 && m_rd[m_owner] != wr[m_owner] && !stl[m_owner] && st_full == 0)
            exp_ack[m_owner] = 1'b1;
        if (st_full > 0) st_full--;
    endtask

    // Edge effects: model consumes its predicted ack, environment pops on the DUT's ack.
    task automatic advance(input logic [NP-1:0] a);
        logic [NP-1:0] req_before;
        flit_t f;
        bit cleared, found;
        int q;
        req_before = req_reg;
        if (m_owner >= 0) begin
            if (exp_ack[m_owner]) begin
                f = mem[m_owner][m_rd[m_owner] % DEPTH];
                m_rd[m_owner]++;
                exp_q.push_back(f);
                if (f.cmd == C_TAIL) begin
                    m_ptr   = (m_owner + 1) % NP;
                    m_owner = -1;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < NP; k++) begin
                q = (m_ptr + k) % NP;
                if (!found && req_before[q]) begin
                    m_owner = q;
                    found   = 1'b1;
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            cleared = 1'b0;
            if (a[p] && rd[p] != wr[p]) begin
                if (mem[p][rd[p] % DEPTH].cmd == C_TAIL) begin
                    req_reg[p] = 1'b0;
                    cleared    = 1'b1;
                end
                rd[p]++;
            end
            if (!req_reg[p] && !cleared && rd[p] != wr[p] && mem[p][rd[p] % DEPTH].cmd == C_HEAD)
                req_reg[p] = 1'b1;
        end
    endtask

    task automatic step();
        logic [NP-1:0] a;
        @(negedge clk);
        a = ack;
        @(posedge clk);
        #1;
        advance(a);
        drive();
    endtask

    function automatic bit all_idle();
        bit ok;
        ok = (m_owner < 0) && (exp_q.size() == 0) && (req_reg == '0);
        for (int p = 0; p < NP; p++) ok = ok && (rd[p] == wr[p]) && (m_rd[p] == wr[p]);
        return ok;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!all_idle()) begin
            step();
            n++;
            if (n > 3000) begin
                $display("FAIL drain_timeout: %0d queued flits still pending after %0d cycles, required 0", exp_q.size(), n);
                $fatal(1, "drain bound expired");
            end
        end
        step();
        step();
    endtask

    task automatic flush_env();
        for (int p = 0; p < NP; p++) begin
            rd[p] = wr[p];
            m_rd[p] = wr[p];
            st_empty[p] = 0;
        end
        st_full = 0;
        req_reg = '0;
        m_owner = -1;
        m_ptr   = 0;
        exp_q.delete();
        exp_head_q.delete();
        drive();
    endtask

    // Called just after a step (posedge+1): asserts reset between edges.
    task automatic do_reset();
        #1;
        rst    = 1'b0;
        chk_en = 1'b0;
        flush_env();
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        for (int p = 0; p < NP; p++) begin
            wr[p] = 0;
            for (int i = 0; i < DEPTH; i++) mem[p][i] = '0;
        end
        flush_env();
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;

        // Single packet on input 2, then 0 and 3 together: rr_ptr=3 must favour 3.
        add_pkt(2, 3, 1'b0);
        drain();
        add_pkt(0, 2, 1'b0);
        add_pkt(3, 2, 1'b0);
        exp_head_q.push_back(3);
        exp_head_q.push_back(0);
        drain();

        // All four at once after reset: order 0..3 with one idle cycle between packets.
        step();
        do_reset();
        gap_chk = 1'b1;
        for (int p = 0; p < NP; p++) begin
            add_pkt(p, 2, 1'b0);
            exp_head_q.push_back(p);
        end
        drain();
        gap_chk = 1'b0;

        // Input 1 empty for 2 cycles mid-packet.
        add_pkt(1, 6, 1'b0);
        repeat (3) step();
        st_empty[1] = 2;
        drain();

        // Downstream full for 3 cycles during input 3's packet.
        add_pkt(3, 6, 1'b0);
        repeat (3) step();
        st_full = 3;
        drain();

        // Input 0 back-to-back plus input 2: after 0's tail, 2 goes before 0.
        add_pkt(0, 4, 1'b0);
        add_pkt(0, 3, 1'b0);
        add_pkt(2, 3, 1'b0);
        exp_head_q.push_back(0);
        exp_head_q.push_back(2);
        exp_head_q.push_back(0);
        drain();

        // Reset mid-packet, then a fresh packet from input 1.
        add_pkt(1, 6, 1'b0);
        repeat (4) step();
        do_reset();
        add_pkt(1, 3, 1'b0);
        exp_head_q.push_back(1);
        drain();

        // Randomized traffic with stalls and stray mid-packet HEADs.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int p;
                p = $urandom_range(0, NP - 1);
                if (wr[p] - rd[p] < 40) add_pkt(p, $urandom_range(2, 5), 1'b1);
            end
            if ($urandom_range(0, 15) == 0) st_empty[$urandom_range(0, NP - 1)] = $urandom_range(1, 3);
            if ($urandom_range(0, 19) == 0) st_full = $urandom_range(1, 3);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/osbm.md
Name: osbm

Overview:
- Output-side switch buffer manager: one instance per output port of the 4-way switch.
- Collects the per-input request vectors that the input-side managers latch on a packet head flit.
- Grants one input at a time in round-robin order, drives that input's ack (its FIFO read enable) and forwards its flits to the output link until the tail flit passes.
- Sits between the input FIFOs and the output link/FIFO; it is the granting end of the req/ack handshake.

Parameters:
- NPORT, 4, number of input ports (equals `PORT+1).
- OUT_ID, 0, index of this output in each input's req vector.
- DW, 32, flit payload width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_in  input  NPORT*NPORT  flattened request vectors; bits [p*NPORT +: NPORT] come from input p; only bit OUT_ID of each slice is used.
- empty  input  NPORT  per-input FIFO empty.
- din  input  NPORT*DW  per-input FIFO head payload (show-ahead), slice p*DW.
- cmd_in  input  NPORT*2  per-input FIFO head command, slice p*2.
- full  input  1  downstream output FIFO/link cannot accept a flit.
- ack  output  NPORT  per-input grant/read enable, one-hot or zero.
- dout  output  DW  forwarded payload (registered).
- cmd_out  output  2  forwarded command (registered).
- we  output  1  dout/cmd_out valid this cycle (registered).

Behaviour:
- Commands: 2'b10 HEAD, 2'b11 TAIL, 2'b01 BODY, 2'b00 idle.
- Reset (rst=0, asynchronous): state=IDLE, grant=0, rr_ptr=0, ack=0, we=0, dout=0, cmd_out=0.
- Candidate vector: cand[p] = req_in[p*NPORT+OUT_ID].
- State IDLE:
  - If any cand is set: pick the first set p searching rr_ptr, rr_ptr+1, … mod NPORT.
  - Registers grant<=p and state<=GRANT.
  - ack stays 0 in IDLE.
- State GRANT:
  - ack[grant] = !empty[grant] && !full (combinational from registered state); all other ack bits are 0.
  - Transfer when ack[grant]=1: next edge dout<=din[grant], cmd_out<=cmd_in[grant], we<=1.
  - Otherwise: we<=0 and dout/cmd_out hold.
  - Transfer with cmd_in[grant]==TAIL: state<=IDLE, rr_ptr<=(grant+1) mod NPORT.
  - The same edge clears the input's req, so a new arbitration starts the cycle after the tail.
- Latency: IDLE→first ack is 1 cycle after req is visible. Flit appears on dout 1 cycle after its ack cycle. Minimum gap between packets is 1 idle cycle; the tail edge and the new-grant edge never coincide.
- Grant is held for the whole packet regardless of cand; a req dropping mid-packet does not release the grant, only TAIL does.
- Empty or full mid-packet: bubble (ack=0, we=0), grant held; resumes when the condition clears.
- Simultaneous requests: strict round-robin; a port that just finished has lowest priority next round.
- A HEAD seen mid-packet on the granted input is forwarded unchanged; only TAIL ends the grant.
- Reset asserted mid-packet: immediate return to IDLE, outputs zero; any partial packet is the source's responsibility.
- At most one ack bit is ever high.

Test Plan:
- Single packet, input 2 only: cand=0100, HEAD,BODY,TAIL on input 2 → grant after 1 cycle; ack=0100 for 3 cycles; we=1 for 3 cycles carrying 10,01,11; then IDLE with rr_ptr=3.
- All four inputs request at once after reset, 2-flit packets → service order 0,1,2,3; ack never multi-hot; exactly 1 idle cycle between packets.
- Input 1 empty for 2 cycles mid-packet → ack=0 and we=0 for exactly those cycles; payload order preserved; grant still 1.
- full=1 for 3 cycles during packet from input 3 → no ack and no we during stall; no flit lost or duplicated.
- Inputs 0 and 2 request again right after input 0's tail with rr_ptr=1 → input 2 is granted before input 0.
- rst pulsed low mid-packet → ack, we, dout and cmd_out are 0 asynchronously; after release a fresh HEAD from input 1 is granted normally.
